// File: rtl/frog_collision_ctrl.sv
// Frog game-state stage: hit/goal detection, lives, score, respawn pulse and game-over.
// Optional best-score tracking is enabled by defining FROG_HIGHSCORE_EN.
module frog_collision_ctrl #(
  parameter int unsigned LIVES    = 3,
  parameter int unsigned LIFE_W   = 2,
  parameter int unsigned SCORE_W  = 4,
  parameter int unsigned HIT_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pause,
  input  logic                  restart,
  input  logic [15:0][15:0]     greenArray,
  input  logic [15:0][15:0]     redArray,
  output logic                  resetField,
  output logic                  hitActive,
  output logic [LIFE_W-1:0]     lives,
  output logic [SCORE_W-1:0]    score,
  output logic                  gameOver,
  output logic [SCORE_W-1:0]    highScore
);

  localparam logic [2:0] S_PLAY    = 3'd0;
  localparam logic [2:0] S_HIT     = 3'd1;
  localparam logic [2:0] S_RESPAWN = 3'd2;
  localparam logic [2:0] S_SETTLE  = 3'd3;
  localparam logic [2:0] S_OVER    = 3'd4;

  localparam int unsigned HC_W = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
  localparam logic [HC_W-1:0]   HC_LAST    = HC_W'(HIT_HOLD - 1);
  localparam logic [LIFE_W-1:0] LIVES_INIT = LIFE_W'(LIVES);

  logic [2:0]         r_state, w_next;
  logic [HC_W-1:0]    r_hold, w_hold_nx;
  logic [LIFE_W-1:0]  r_lives, w_lives_nx;
  logic [SCORE_W-1:0] r_score, w_score_nx;
  logic               r_respawn, r_hitActive, r_gameOver;
  logic               w_hit, w_goal;

  assign w_hit  = |(greenArray & redArray);
  assign w_goal = |greenArray[15];

  always_comb begin
    w_next     = r_state;
    w_hold_nx  = r_hold;
    w_lives_nx = r_lives;
    w_score_nx = r_score;
    case (r_state)
      S_PLAY: begin
        if (!pause) begin
          if (w_hit) begin
            w_next    = S_HIT;
            w_hold_nx = '0;
            if (r_lives != '0) w_lives_nx = r_lives - 1'b1;
          end else if (w_goal) begin
            w_next = S_RESPAWN;
            if (!(&r_score)) w_score_nx = r_score + 1'b1;
          end
        end
      end
      S_HIT: begin
        if (!pause) begin
          if (r_hold == HC_LAST) begin
            w_next    = (r_lives == '0) ? S_OVER : S_RESPAWN;
            w_hold_nx = '0;
          end else begin
            w_hold_nx = r_hold + 1'b1;
          end
        end
      end
      S_RESPAWN: if (!pause) w_next = S_SETTLE;
      S_SETTLE:  if (!pause) w_next = S_PLAY;
      S_OVER: begin
        if (restart) begin
          w_next     = S_RESPAWN;
          w_lives_nx = LIVES_INIT;
          w_score_nx = '0;
        end
      end
      default: w_next = S_PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_PLAY;
      r_hold      <= '0;
      r_lives     <= LIVES_INIT;
      r_score     <= '0;
      r_respawn   <= 1'b0;
      r_hitActive <= 1'b0;
      r_gameOver  <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_hold      <= w_hold_nx;
      r_lives     <= w_lives_nx;
      r_score     <= w_score_nx;
      r_respawn   <= (w_next == S_RESPAWN);
      r_hitActive <= (w_next == S_HIT);
      r_gameOver  <= (w_next == S_OVER);
    end
  end

  // RESPAWN is held while paused, so the pulse lands on the first unpaused cycle.
  assign resetField = r_respawn & ~pause;
  assign hitActive  = r_hitActive;
  assign gameOver   = r_gameOver;
  assign lives      = r_lives;
  assign score      = r_score;

`ifdef FROG_HIGHSCORE_EN
  logic [SCORE_W-1:0] r_highScore;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_highScore <= '0;
    end else if (w_next == S_OVER && r_state != S_OVER && r_score > r_highScore) begin
      r_highScore <= r_score;
    end
  end

  assign highScore = r_highScore;
`else
  assign highScore = '0;
`endif

endmodule

// File: tb/tb_frog_collision_ctrl.sv
// Bench for frog_collision_ctrl: vector table plus hand-built multi-cycle sequences.
module tb_frog_collision_ctrl;

  typedef struct {
    logic [3:0] fr, fc; logic fe;
    logic [3:0] cr, cc; logic ce;
    logic pz, rs;
    logic e_rf, e_hit; logic [1:0] e_l; logic [3:0] e_s; logic e_ov;
  } vec_t;

`ifdef FROG_HIGHSCORE_EN
  localparam bit HS_EN = 1'b1;
`else
  localparam bit HS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, pause, restart;
  logic [15:0][15:0] greenArray, redArray;
  logic resetField, hitActive, gameOver;
  logic [1:0] lives;
  logic [3:0] score, highScore;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [3:0] exp_hs = '0;
  vec_t sb[$];
  vec_t tbl[31];

  always #5 clk = ~clk;

  frog_collision_ctrl #(.LIVES(3), .LIFE_W(2), .SCORE_W(4), .HIT_HOLD(8)) dut (
    .clk(clk), .reset(reset), .pause(pause), .restart(restart),
    .greenArray(greenArray), .redArray(redArray),
    .resetField(resetField), .hitActive(hitActive), .lives(lives),
    .score(score), .gameOver(gameOver), .highScore(highScore)
  );

  function automatic vec_t mk(input logic [3:0] fr, fc, input logic fe,
                              input logic [3:0] cr, cc, input logic ce,
                              input logic pz, rs, rf, hit, input logic [1:0] l,
                              input logic [3:0] s, input logic ov);
    vec_t v;
    v.fr = fr; v.fc = fc; v.fe = fe; v.cr = cr; v.cc = cc; v.ce = ce;
    v.pz = pz; v.rs = rs; v.e_rf = rf; v.e_hit = hit; v.e_l = l; v.e_s = s; v.e_ov = ov;
    return v;
  endfunction

  // Idle frog at [0][9], no cars.
  function automatic vec_t idle(input logic pz, rf, hit, input logic [1:0] l,
                                input logic [3:0] s, input logic ov);
    return mk(4'd0, 4'd9, 1'b1, 4'd0, 4'd0, 1'b0, pz, 1'b0, rf, hit, l, s, ov);
  endfunction

  function automatic vec_t crash(input logic rf, hit, input logic [1:0] l,
                                 input logic [3:0] s, input logic ov);
    return mk(4'd0, 4'd9, 1'b1, 4'd0, 4'd9, 1'b1, 1'b0, 1'b0, rf, hit, l, s, ov);
  endfunction

  function automatic vec_t goal(input logic rf, input logic [1:0] l, input logic [3:0] s);
    return mk(4'd15, 4'd4, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, rf, 1'b0, l, s, 1'b0);
  endfunction

  function automatic logic [15:0][15:0] bmap(input logic [3:0] r, c, input logic en);
    logic [15:0][15:0] m;
    m = '0;
    if (en) m[r][c] = 1'b1;
    return m;
  endfunction

  task automatic compare(input string nm, input vec_t e);
    n_checks++;
    if (resetField !== e.e_rf || hitActive !== e.e_hit || lives !== e.e_l ||
        score !== e.e_s || gameOver !== e.e_ov || highScore !== exp_hs) begin
      n_errors++;
      $display("FAIL %s: got rf=%0b hit=%0b lives=%0d score=%0d over=%0b hs=%0d, want rf=%0b hit=%0b lives=%0d score=%0d over=%0b hs=%0d",
               nm, resetField, hitActive, lives, score, gameOver, highScore,
               e.e_rf, e.e_hit, e.e_l, e.e_s, e.e_ov, exp_hs);
    end
  endtask

  // Inputs change on negedge; outputs for that cycle are checked 1ns later.
  task automatic step(input string nm, input vec_t v);
    vec_t e;
    @(negedge clk);
    greenArray = bmap(v.fr, v.fc, v.fe);
    redArray   = bmap(v.cr, v.cc, v.ce);
    pause      = v.pz;
    restart    = v.rs;
    sb.push_back(v);
    #1;
    e = sb.pop_front();
    compare(nm, e);
  endtask

  task automatic hit_cycle(input string nm, input logic [1:0] l0, input logic [3:0] s);
    step(nm, crash(1'b0, 1'b0, l0, s, 1'b0));
    for (int i = 0; i < 8; i++) step(nm, idle(1'b0, 1'b0, 1'b1, l0 - 2'd1, s, 1'b0));
  endtask

  initial begin
    // Scenario table starting from reset: lives=3, score=0.
    tbl[0]  = idle(1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0);
    tbl[1]  = mk(4'd0, 4'd0, 1'b0, 4'd5, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0);
    tbl[2]  = crash(1'b0, 1'b0, 2'd3, 4'd0, 1'b0);
    tbl[3]  = idle(1'b0, 1'b0, 1'b1, 2'd2, 4'd0, 1'b0);
    tbl[4]  = crash(1'b0, 1'b1, 2'd2, 4'd0, 1'b0);
    for (int i = 5; i <= 10; i++) tbl[i] = idle(1'b0, 1'b0, 1'b1, 2'd2, 4'd0, 1'b0);
    tbl[11] = crash(1'b1, 1'b0, 2'd2, 4'd0, 1'b0);
    tbl[12] = crash(1'b0, 1'b0, 2'd2, 4'd0, 1'b0);
    tbl[13] = idle(1'b0, 1'b0, 1'b0, 2'd2, 4'd0, 1'b0);
    tbl[14] = goal(1'b0, 2'd2, 4'd0);
    tbl[15] = goal(1'b1, 2'd2, 4'd1);
    tbl[16] = goal(1'b0, 2'd2, 4'd1);
    tbl[17] = idle(1'b0, 1'b0, 1'b0, 2'd2, 4'd1, 1'b0);
    tbl[18] = mk(4'd15, 4'd2, 1'b1, 4'd15, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'd1, 1'b0);
    for (int i = 19; i <= 26; i++) tbl[i] = idle(1'b0, 1'b0, 1'b1, 2'd1, 4'd1, 1'b0);
    tbl[27] = idle(1'b0, 1'b1, 1'b0, 2'd1, 4'd1, 1'b0);
    tbl[28] = idle(1'b0, 1'b0, 1'b0, 2'd1, 4'd1, 1'b0);
    tbl[29] = mk(4'd0, 4'd9, 1'b1, 4'd0, 4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 4'd1, 1'b0);
    tbl[30] = idle(1'b0, 1'b0, 1'b0, 2'd1, 4'd1, 1'b0);

    reset = 1'b0; pause = 1'b0; restart = 1'b0;
    greenArray = bmap(4'd0, 4'd9, 1'b1);
    redArray   = '0;
    repeat (3) @(negedge clk);
    #1 compare("reset_state", idle(1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0));
    reset = 1'b1;

    for (int i = 0; i < 31; i++) step($sformatf("tbl%0d", i), tbl[i]);

    // Last life lost: HIT then OVER with no respawn pulse.
    hit_cycle("last_hit", 2'd1, 4'd1);
    exp_hs = HS_EN ? 4'd1 : 4'd0;
    step("enter_over", idle(1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 1'b1));
    for (int i = 0; i < 6; i++)
      step("hold_over", mk(4'd0, 4'd9, 1'b1, 4'd0, 4'd9, i[0], i[0], 1'b0,
                           1'b0, 1'b0, 2'd0, 4'd1, 1'b1));
    step("restart_req", mk(4'd0, 4'd9, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1,
                           1'b0, 1'b0, 2'd0, 4'd1, 1'b1));
    step("respawn_paused0", idle(1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0));
    step("respawn_paused1", idle(1'b1, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0));
    step("restart_pulse", idle(1'b0, 1'b1, 1'b0, 2'd3, 4'd0, 1'b0));
    step("restart_settle", idle(1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0));
    step("restart_play", idle(1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0));

    // Pause for 5 cycles mid-HIT delays the pulse by 5 cycles.
    step("phit_car", crash(1'b0, 1'b0, 2'd3, 4'd0, 1'b0));
    for (int i = 0; i < 3; i++) step("phit_run", idle(1'b0, 1'b0, 1'b1, 2'd2, 4'd0, 1'b0));
    for (int i = 0; i < 5; i++) step("phit_frozen", idle(1'b1, 1'b0, 1'b1, 2'd2, 4'd0, 1'b0));
    for (int i = 0; i < 5; i++) step("phit_resume", idle(1'b0, 1'b0, 1'b1, 2'd2, 4'd0, 1'b0));
    step("phit_pulse", idle(1'b0, 1'b1, 1'b0, 2'd2, 4'd0, 1'b0));
    step("phit_settle", idle(1'b0, 1'b0, 1'b0, 2'd2, 4'd0, 1'b0));

    // Paused goal is not scored until pause drops.
    step("pgoal_paused", mk(4'd15, 4'd4, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0,
                            1'b0, 1'b0, 2'd2, 4'd0, 1'b0));
    for (int s = 0; s < 15; s++) begin
      step("sat_goal", goal(1'b0, 2'd2, 4'(s)));
      step("sat_pulse", goal(1'b1, 2'd2, 4'(s + 1)));
      step("sat_settle", idle(1'b0, 1'b0, 1'b0, 2'd2, 4'(s + 1), 1'b0));
    end
    step("sat_goal16", goal(1'b0, 2'd2, 4'd15));
    step("sat_hold", idle(1'b0, 1'b1, 1'b0, 2'd2, 4'd15, 1'b0));
    step("sat_settle16", idle(1'b0, 1'b0, 1'b0, 2'd2, 4'd15, 1'b0));

    hit_cycle("over2_hit1", 2'd2, 4'd15);
    step("over2_pulse", idle(1'b0, 1'b1, 1'b0, 2'd1, 4'd15, 1'b0));
    step("over2_settle", idle(1'b0, 1'b0, 1'b0, 2'd1, 4'd15, 1'b0));
    hit_cycle("over2_hit2", 2'd1, 4'd15);
    exp_hs = HS_EN ? 4'd15 : 4'd0;
    step("over2_enter", idle(1'b0, 1'b0, 1'b0, 2'd0, 4'd15, 1'b1));

    // Restart keeps highScore; asynchronous reset mid-HIT clears everything.
    step("rst_restart", mk(4'd0, 4'd9, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1,
                           1'b0, 1'b0, 2'd0, 4'd15, 1'b1));
    step("rst_resp", idle(1'b0, 1'b1, 1'b0, 2'd3, 4'd0, 1'b0));
    step("rst_settle", idle(1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0));
    step("rst_car", crash(1'b0, 1'b0, 2'd3, 4'd0, 1'b0));
    step("rst_inhit", idle(1'b0, 1'b0, 1'b1, 2'd2, 4'd0, 1'b0));
    #2 reset = 1'b0;
    #1 exp_hs = '0;
    compare("async_reset", idle(1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0));
    repeat (2) @(negedge clk);
    #1 compare("reset_held", idle(1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0));
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step("post_reset", idle(1'b0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
